hub75_scan_sched: RTL and testbench
===================================

# hub75_scan_sched

Row-scan scheduler that sequences the HUB75 framebuffer read-out side and the panel shifter. For each display row it preloads the next row from the framebuffer, waits for both the preload and the shifter to be ready, swaps the read-out line buffer, and launches the shift. It also holds writer frame-swap requests and applies them only at the frame boundary, after the last row has been swapped in. It sits between the framebuffer's read-out/frame-swap ports and the shifter/BCM block.

## Interface

- N_ROWS, 32, rows per bank scanned per frame; must be a power of 2, minimum 2.
- LOG_N_ROWS, $clog2(N_ROWS), row address width; auto-set.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_run  in  1  level; 1 = scan, 0 = stop at the next row boundary.
- rd_row_addr  out  LOG_N_ROWS  row to preload; valid while rd_row_load = 1.
- rd_row_load  out  1  one-cycle preload strobe to the framebuffer.
- rd_row_rdy  in  1  framebuffer preload complete.
- rd_row_swap  out  1  one-cycle line-buffer swap strobe.
- shift_rdy  in  1  shifter idle and previous row's display time elapsed.
- shift_go  out  1  one-cycle shifter start strobe.
- disp_row_addr  out  LOG_N_ROWS  row currently being shifted/displayed.
- swap_req  in  1  one-cycle writer request for a frame swap.
- swap_ack  out  1  one-cycle pulse; the request has been applied.
- frame_swap  out  1  one-cycle strobe to the framebuffer double-buffer toggle.
- frame_start  out  1  one-cycle pulse on the shift_go for row 0.

## Operation

- States: IDLE, LOAD, WAIT_LOAD, WAIT_SHIFT, SWAP, SHIFT.
- IDLE: row counter forced to 0. Goes to LOAD when ctrl_run = 1.
- LOAD: rd_row_load = 1 for one cycle, with rd_row_addr = row counter. Goes to WAIT_LOAD.
- WAIT_LOAD: rd_row_rdy is ignored in the first cycle, which masks a stale ready. From the second cycle on, goes to WAIT_SHIFT when rd_row_rdy = 1.
- WAIT_SHIFT: goes to SWAP when shift_rdy = 1.
- SWAP: rd_row_swap = 1 for one cycle, and disp_row_addr <= row counter.
  - If the row counter is N_ROWS-1 and swap_pend = 1: frame_swap = 1 and swap_ack = 1 in this same cycle, and swap_pend clears.
  - Goes to SHIFT.
- SHIFT: shift_go = 1 for one cycle. frame_start = 1 if disp_row_addr = 0.
  - Row counter increments modulo N_ROWS, so N_ROWS-1 wraps to 0.
  - Goes to LOAD if ctrl_run = 1, otherwise IDLE.
- swap_pend is set by swap_req in any state, including IDLE.
  - swap_req in the same cycle as frame_swap keeps swap_pend = 1, so the new request applies at the next frame end.
  - Multiple requests within one frame collapse into a single swap.
- ctrl_run only acts in SHIFT; a row in progress always completes. A pending swap survives a stop/restart.
- rd_row_addr always reflects the row counter; it is meaningful only during LOAD.

## Timing

- Reset values: state IDLE, row counter 0, rd_row_addr 0, disp_row_addr 0, swap_pend 0. Every strobe output (rd_row_load, rd_row_swap, shift_go, swap_ack, frame_swap, frame_start) is 0.
- Every strobe is registered and lasts exactly one cycle.
- ctrl_run rising in IDLE: rd_row_load is high 1 cycle later.
- Minimum row period is 6 cycles (LOAD 1, WAIT_LOAD 2, WAIT_SHIFT 1, SWAP 1, SHIFT 1), reached when rd_row_rdy and shift_rdy are both already high.
- Ordering within a row: rd_row_swap is always exactly one cycle before shift_go.
- frame_swap, when issued, coincides with rd_row_swap of row N_ROWS-1. Row 0 of the next frame is therefore loaded from the new buffer.
- Reset asserted mid-row: immediate return to reset values. No strobe may be emitted while rst = 1.

## Test plan

- N_ROWS = 4, ctrl_run = 1, rd_row_rdy and shift_rdy tied high:
  - rd_row_load pulses every 6 cycles with rd_row_addr sequence 0,1,2,3,0.
  - frame_start fires once per 24 cycles.
- rd_row_rdy held high continuously, shift_rdy high: WAIT_LOAD still lasts exactly 2 cycles.
- shift_rdy held low for 10 cycles after WAIT_SHIFT is entered: rd_row_swap is delayed until 1 cycle after shift_rdy rises, and no other strobe fires in the meantime.
- swap_req pulsed during row 1, then again during row 2 of the same frame:
  - exactly one frame_swap/swap_ack pair, coincident with rd_row_swap of row 3.
- swap_req in the same cycle as frame_swap: a second frame_swap occurs at the row-3 swap of the following frame.
- ctrl_run dropped during WAIT_LOAD of row 2:
  - row 2 completes (swap, then shift_go), then IDLE.
  - on restart, rd_row_addr = 0.
- rst pulsed during SWAP: all outputs are 0 in the next cycle, and the scan restarts at row 0.

Source files
------------

// File: rtl/hub75_scan_sched.sv
// hub75_scan_sched: row-scan scheduler pairing framebuffer row preload with the panel shifter,
// applying writer frame swaps only at the frame boundary.
module hub75_scan_sched #(
   parameter int N_ROWS     = 32,
   parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_run_i,
   output logic [LOG_N_ROWS-1:0] rd_row_addr_o,
   output logic                  rd_row_load_o,
   input  logic                  rd_row_rdy_i,
   output logic                  rd_row_swap_o,
   input  logic                  shift_rdy_i,
   output logic                  shift_go_o,
   output logic [LOG_N_ROWS-1:0] disp_row_addr_o,
   input  logic                  swap_req_i,
   output logic                  swap_ack_o,
   output logic                  frame_swap_o,
   output logic                  frame_start_o
);
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] LOAD       = 3'd1;
   localparam logic [2:0] WAIT_LOAD  = 3'd2;
   localparam logic [2:0] WAIT_SHIFT = 3'd3;
   localparam logic [2:0] SWAP       = 3'd4;
   localparam logic [2:0] SHIFT      = 3'd5;
   logic [2:0]            state_q, state_d;
   logic [LOG_N_ROWS-1:0] row_q, row_d, disp_q, disp_d;
   logic                  first_q, pend_q, pend_d, fswap_q, fswap_d;
   logic                  load_q, rswap_q, go_q, fstart_q;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       state_d = ctrl_run_i ? LOAD : IDLE;
         LOAD:       state_d = WAIT_LOAD;
         // first WAIT_LOAD cycle ignores a ready left over from the previous row
         WAIT_LOAD:  state_d = (!first_q && rd_row_rdy_i) ? WAIT_SHIFT : WAIT_LOAD;
         WAIT_SHIFT: state_d = shift_rdy_i ? SWAP : WAIT_SHIFT;
         SWAP:       state_d = SHIFT;
         SHIFT:      state_d = ctrl_run_i ? LOAD : IDLE;
         default:    state_d = IDLE;
      endcase
      row_d   = (state_q == IDLE) ? '0 : (state_q == SHIFT) ? row_q + 1'b1 : row_q;
      disp_d  = (state_q == SWAP) ? row_q : disp_q;
      pend_d  = swap_req_i | (pend_q & ~fswap_q);
      fswap_d = (state_d == SWAP) && (&row_q) && pend_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         row_q    <= '0;
         disp_q   <= '0;
         pend_q   <= 1'b0;
         first_q  <= 1'b0;
         load_q   <= 1'b0;
         rswap_q  <= 1'b0;
         go_q     <= 1'b0;
         fswap_q  <= 1'b0;
         fstart_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         first_q  <= (state_q == LOAD);
         load_q   <= (state_d == LOAD);
         rswap_q  <= (state_d == SWAP);
         go_q     <= (state_d == SHIFT);
         fswap_q  <= fswap_d;
         fstart_q <= (state_d == SHIFT) && (disp_d == '0);
      end
   end
   assign rd_row_addr_o   = row_q;
   assign rd_row_load_o   = load_q;
   assign rd_row_swap_o   = rswap_q;
   assign shift_go_o      = go_q;
   assign disp_row_addr_o = disp_q;
   assign swap_ack_o      = fswap_q;
   assign frame_swap_o    = fswap_q;
   assign frame_start_o   = fstart_q;
endmodule

// File: tb/tb_hub75_scan_sched.sv
// tb_hub75_scan_sched: directed scenarios for the row-scan scheduler with N_ROWS = 4.
module tb_hub75_scan_sched;
   logic       clk = 1'b0, rst = 1'b1;
   logic       ctrl_run = 1'b0, rd_row_rdy = 1'b0, shift_rdy = 1'b0, swap_req = 1'b0;
   logic [1:0] rd_row_addr, disp_row_addr;
   logic       rd_row_load, rd_row_swap, shift_go, swap_ack, frame_swap, frame_start;
   logic [5:0] strobes;
   int         k = 0, checks = 0, errors = 0;
   always #5 clk = ~clk;
   hub75_scan_sched #(.N_ROWS(4)) dut (
      .clk(clk), .rst(rst), .ctrl_run_i(ctrl_run),
      .rd_row_addr_o(rd_row_addr), .rd_row_load_o(rd_row_load), .rd_row_rdy_i(rd_row_rdy),
      .rd_row_swap_o(rd_row_swap), .shift_rdy_i(shift_rdy), .shift_go_o(shift_go),
      .disp_row_addr_o(disp_row_addr), .swap_req_i(swap_req), .swap_ack_o(swap_ack),
      .frame_swap_o(frame_swap), .frame_start_o(frame_start)
   );
   assign strobes = {rd_row_load, rd_row_swap, shift_go, swap_ack, frame_swap, frame_start};
   task automatic tick;
      @(posedge clk);
      #1;
      k++;
   endtask
   // after this, k = 1 is the LOAD cycle of row 0
   task automatic restart(input logic sr);
      rst = 1'b1; ctrl_run = 1'b0; swap_req = 1'b0; rd_row_rdy = 1'b1; shift_rdy = sr;
      tick; tick;
      rst = 1'b0; ctrl_run = 1'b1; k = 0;
      tick;
   endtask
   task automatic test_reset;
      ctrl_run = 1'b1; rd_row_rdy = 1'b1; shift_rdy = 1'b1; swap_req = 1'b1;
      repeat (3) tick;
      checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", strobes); end
      checks++; if (rd_row_addr !== 2'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", rd_row_addr); end
      checks++; if (disp_row_addr !== 2'd0) begin errors++; $display("FAIL reset_disp_addr got %0d exp 0", disp_row_addr); end
   endtask
   task automatic test_free_run;
      restart(1'b1);
      repeat (48) begin
         checks++; if (rd_row_load !== (k % 6 == 1)) begin errors++; $display("FAIL run_load k=%0d got %b exp %b", k, rd_row_load, k % 6 == 1); end
         if (k % 6 == 1) begin
            checks++; if (rd_row_addr !== 2'((k - 1) / 6 % 4)) begin errors++; $display("FAIL run_addr k=%0d got %0d exp %0d", k, rd_row_addr, (k - 1) / 6 % 4); end
         end
         checks++; if (rd_row_swap !== (k % 6 == 5)) begin errors++; $display("FAIL run_swap k=%0d got %b exp %b", k, rd_row_swap, k % 6 == 5); end
         checks++; if (shift_go !== (k % 6 == 0)) begin errors++; $display("FAIL run_go k=%0d got %b exp %b", k, shift_go, k % 6 == 0); end
         checks++; if (frame_start !== (k % 24 == 6)) begin errors++; $display("FAIL run_fstart k=%0d got %b exp %b", k, frame_start, k % 24 == 6); end
         checks++; if (frame_swap !== 1'b0) begin errors++; $display("FAIL run_fswap k=%0d got %b exp 0", k, frame_swap); end
         tick;
      end
   endtask
   task automatic test_shift_stall;
      restart(1'b0);
      checks++; if (rd_row_load !== 1'b1) begin errors++; $display("FAIL stall_load got %b exp 1", rd_row_load); end
      while (k < 13) begin
         tick;
         checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL stall_quiet k=%0d got %b exp 000000", k, strobes); end
      end
      shift_rdy = 1'b1;
      tick;
      checks++; if (strobes !== 6'b010000) begin errors++; $display("FAIL stall_swap got %b exp 010000", strobes); end
      tick;
      checks++; if (strobes !== 6'b001001) begin errors++; $display("FAIL stall_go got %b exp 001001", strobes); end
   endtask
   task automatic test_swap_collapse;
      restart(1'b1);
      repeat (48) begin
         checks++; if (frame_swap !== (k == 23)) begin errors++; $display("FAIL collapse_fswap k=%0d got %b exp %b", k, frame_swap, k == 23); end
         checks++; if (swap_ack !== (k == 23)) begin errors++; $display("FAIL collapse_ack k=%0d got %b exp %b", k, swap_ack, k == 23); end
         if (k == 23) begin
            checks++; if (rd_row_swap !== 1'b1) begin errors++; $display("FAIL collapse_rswap got %b exp 1", rd_row_swap); end
         end
         swap_req = (k == 8 || k == 15);
         tick;
      end
      swap_req = 1'b0;
   endtask
   task automatic test_swap_same_cycle;
      restart(1'b1);
      repeat (50) begin
         checks++; if (frame_swap !== (k == 23 || k == 47)) begin errors++; $display("FAIL same_fswap k=%0d got %b exp %b", k, frame_swap, k == 23 || k == 47); end
         swap_req = (k == 2 || k == 23);
         tick;
      end
      swap_req = 1'b0;
   endtask
   task automatic test_stop;
      restart(1'b1);
      repeat (30) begin
         checks++; if (rd_row_load !== (k == 1 || k == 7 || k == 13)) begin errors++; $display("FAIL stop_load k=%0d got %b", k, rd_row_load); end
         checks++; if (rd_row_swap !== (k % 6 == 5 && k <= 17)) begin errors++; $display("FAIL stop_swap k=%0d got %b", k, rd_row_swap); end
         checks++; if (shift_go !== (k % 6 == 0 && k <= 18)) begin errors++; $display("FAIL stop_go k=%0d got %b", k, shift_go); end
         if (k == 18) begin
            checks++; if (disp_row_addr !== 2'd2) begin errors++; $display("FAIL stop_disp got %0d exp 2", disp_row_addr); end
         end
         ctrl_run = (k < 14);
         tick;
      end
      ctrl_run = 1'b1;
      tick;
      checks++; if (rd_row_load !== 1'b1) begin errors++; $display("FAIL restart_load got %b exp 1", rd_row_load); end
      checks++; if (rd_row_addr !== 2'd0) begin errors++; $display("FAIL restart_addr got %0d exp 0", rd_row_addr); end
   endtask
   task automatic test_reset_mid;
      restart(1'b1);
      while (k < 11) tick;
      checks++; if (rd_row_swap !== 1'b1) begin errors++; $display("FAIL mid_pre_swap got %b exp 1", rd_row_swap); end
      rst = 1'b1;
      #1;
      checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL mid_rst_strobes got %b exp 000000", strobes); end
      checks++; if (rd_row_addr !== 2'd0) begin errors++; $display("FAIL mid_rst_addr got %0d exp 0", rd_row_addr); end
      tick;
      checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL mid_rst_hold got %b exp 000000", strobes); end
      rst = 1'b0;
      tick;
      checks++; if (rd_row_load !== 1'b1 || rd_row_addr !== 2'd0) begin errors++; $display("FAIL mid_restart load=%b addr=%0d exp load=1 addr=0", rd_row_load, rd_row_addr); end
      repeat (5) tick;
      checks++; if (strobes !== 6'b001001) begin errors++; $display("FAIL mid_restart_go got %b exp 001001", strobes); end
   endtask
   initial begin
      test_reset;
      test_free_run;
      test_shift_stall;
      test_swap_collapse;
      test_swap_same_cycle;
      test_stop;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
